pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// One pipeline-stage register with stall, flush (bubble insertion) and
// exception redirect, plus small performance/debug counters.
//
// Update priority on each rising clk edge:
//   reset > req > enable&flush > enable > hold
//
// Ports
//   clk                  single clock, all state updates on rising edge
//   reset                synchronous active-high reset
//   enable               1 = stage advances, 0 = stage holds (stall)
//   req                  exception/interrupt redirect to HANDLER_PC
//   flush                insert a bubble when advancing (ignored on stall)
//   in_valid/in_pc/in_bd/in_exccode/in_a3/in_payload
//                        upstream slot contents
//   out_valid/out_pc/out_bd/out_exccode/out_a3/out_payload
//                        registered stage contents (one-cycle latency)
//   bubble_cnt           bubbles inserted by flush or req, saturating
//   hold_cnt             current run of consecutive stall cycles, saturating
//   stall_wdog           sticky: hold_cnt reached STALL_LIMIT; only reset clears
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W        = 160,
    parameter logic [31:0] RESET_PC         = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC       = 32'h0000_4180,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W            = 16,
    parameter int unsigned STALL_LIMIT      = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [31:0]          in_pc,
    input  logic                 in_bd,
    input  logic [4:0]           in_exccode,
    input  logic [4:0]           in_a3,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [31:0]          out_pc,
    output logic                 out_bd,
    output logic [4:0]           out_exccode,
    output logic [4:0]           out_a3,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     hold_cnt,
    output logic                 stall_wdog
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(STALL_LIMIT);

    // Stage state
    logic                 valid_reg,   valid_next;
    logic [31:0]          pc_reg,      pc_next;
    logic                 bd_reg,      bd_next;
    logic [4:0]           exccode_reg, exccode_next;
    logic [4:0]           a3_reg,      a3_next;
    logic [PAYLOAD_W-1:0] payload_reg, payload_next;

    // Counters and watchdog
    logic [CNT_W-1:0]     bubble_reg,  bubble_next;
    logic [CNT_W-1:0]     hold_reg,    hold_next;
    logic                 wdog_reg,    wdog_next;

    // Saturating increments, computed once and shared by the next-state logic
    logic [CNT_W-1:0]     bubble_inc;
    logic [CNT_W-1:0]     hold_inc;

    // PC/BD carried into a flush bubble: kept for precise exception
    // reporting, or zeroed when the downstream logic wants a clean bubble.
    logic [31:0]          flush_pc;
    logic                 flush_bd;

    generate
        if (KEEP_PC_ON_FLUSH) begin : g_keep_pc
            assign flush_pc = in_pc;
            assign flush_bd = in_bd;
        end else begin : g_zero_pc
            assign flush_pc = 32'h0;
            assign flush_bd = 1'b0;
        end
    endgenerate

    assign bubble_inc = (bubble_reg == CNT_MAX) ? bubble_reg : bubble_reg + CNT_ONE;
    assign hold_inc   = (hold_reg   == CNT_MAX) ? hold_reg   : hold_reg   + CNT_ONE;

    always_comb begin
        // Default: hold everything (stall path)
        valid_next   = valid_reg;
        pc_next      = pc_reg;
        bd_next      = bd_reg;
        exccode_next = exccode_reg;
        a3_next      = a3_reg;
        payload_next = payload_reg;
        bubble_next  = bubble_reg;
        hold_next    = hold_reg;
        wdog_next    = wdog_reg;

        if (req) begin
            // Redirect wins over enable/flush and counts as a bubble
            valid_next   = 1'b0;
            pc_next      = HANDLER_PC;
            bd_next      = 1'b0;
            exccode_next = 5'd0;
            a3_next      = 5'd0;
            payload_next = '0;
            bubble_next  = bubble_inc;
            hold_next    = '0;
        end else if (enable) begin
            hold_next = '0;
            if (flush) begin
                valid_next   = 1'b0;
                pc_next      = flush_pc;
                bd_next      = flush_bd;
                exccode_next = 5'd0;
                a3_next      = 5'd0;
                payload_next = '0;
                bubble_next  = bubble_inc;
            end else begin
                valid_next   = in_valid;
                pc_next      = in_pc;
                bd_next      = in_bd;
                exccode_next = in_exccode;
                a3_next      = in_a3;
                payload_next = in_payload;
            end
        end else begin
            // Stall: flush is deliberately ignored so the held slot survives
            hold_next = hold_inc;
            if (hold_inc == LIMIT_VAL) begin
                wdog_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg   <= 1'b0;
            pc_reg      <= RESET_PC;
            bd_reg      <= 1'b0;
            exccode_reg <= 5'd0;
            a3_reg      <= 5'd0;
            payload_reg <= '0;
            bubble_reg  <= '0;
            hold_reg    <= '0;
            wdog_reg    <= 1'b0;
        end else begin
            valid_reg   <= valid_next;
            pc_reg      <= pc_next;
            bd_reg      <= bd_next;
            exccode_reg <= exccode_next;
            a3_reg      <= a3_next;
            payload_reg <= payload_next;
            bubble_reg  <= bubble_next;
            hold_reg    <= hold_next;
            wdog_reg    <= wdog_next;
        end
    end

    assign out_valid   = valid_reg;
    assign out_pc      = pc_reg;
    assign out_bd      = bd_reg;
    assign out_exccode = exccode_reg;
    assign out_a3      = a3_reg;
    assign out_payload = payload_reg;
    assign bubble_cnt  = bubble_reg;
    assign hold_cnt    = hold_reg;
    assign stall_wdog  = wdog_reg;

endmodule
